// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// FSM state encodings and the requester-id width helper.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_t;

  // Width needed to hold a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set request strictly after ptr,
// wrapping modulo N, is returned both one-hot and as an index.
module rr_priority_picker
  import reg_arb_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    pick,
  output logic [ID_W-1:0] pick_id,
  output logic            any
);

  logic [N-1:0] rot_s;

  // Rotate the request vector so that position 0 is the slot just after ptr.
  always_comb begin
    rot_s = '0;
    for (int k = 0; k < N; k++) begin
      rot_s[k] = req[(int'(ptr) + 1 + k) % N];
    end
  end

  // Priority-encode the rotated vector and map the winner back to its real index.
  always_comb begin
    logic found;
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (rot_s[k] && !found) begin
        found                             = 1'b1;
        pick_id                           = ID_W'((int'(ptr) + 1 + k) % N);
        pick[(int'(ptr) + 1 + k) % N]     = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares one storage register between NUM_REQ write requesters using a
// round-robin IDLE -> GRANT -> ACK sequence per write.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         q,
  output logic                      busy,
  output logic [ID_W-1:0]           last_id
);

  arb_state_t          state_r, state_n;
  logic [ID_W-1:0]     ptr_r, ptr_n;
  logic [ID_W-1:0]     sel_r, sel_n;
  logic [NUM_REQ-1:0]  gnt_r, gnt_n;
  logic [NUM_REQ-1:0]  ack_r, ack_n;
  logic [DATA_W-1:0]   q_r, q_n;
  logic [ID_W-1:0]     last_id_r, last_id_n;
  logic                busy_r;
  logic [NUM_REQ-1:0]  pick_s;
  logic [ID_W-1:0]     pick_id_s;
  logic                any_s;
  logic [DATA_W-1:0]   wsel_s;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .req     (req),
    .ptr     (ptr_r),
    .pick    (pick_s),
    .pick_id (pick_id_s),
    .any     (any_s)
  );

  // Select the granted requester's data lane.
  always_comb begin
    wsel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_r == ID_W'(i)) begin
        wsel_s = wdata[i*DATA_W +: DATA_W];
      end else begin
        wsel_s = wsel_s;
      end
    end
  end

  // Next-state and next-output logic; ack is derived from the held grant so it
  // can only ever appear where gnt is set.
  always_comb begin
    state_n   = state_r;
    ptr_n     = ptr_r;
    sel_n     = sel_r;
    gnt_n     = gnt_r;
    ack_n     = '0;
    q_n       = q_r;
    last_id_n = last_id_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_n = ST_GRANT;
          gnt_n   = pick_s;
          sel_n   = pick_id_s;
        end else begin
          gnt_n   = '0;
        end
      end
      ST_GRANT: begin
        state_n   = ST_ACK;
        q_n       = wsel_s;
        last_id_n = sel_r;
        ptr_n     = sel_r;
        ack_n     = gnt_r;
      end
      ST_ACK: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        ack_n   = '0;
      end
    endcase
  end

  // State and output registers; reset drops any write in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ptr_r     <= ID_W'(NUM_REQ - 1);
      sel_r     <= '0;
      gnt_r     <= '0;
      ack_r     <= '0;
      q_r       <= '0;
      last_id_r <= '0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      ptr_r     <= ptr_n;
      sel_r     <= sel_n;
      gnt_r     <= gnt_n;
      ack_r     <= ack_n;
      q_r       <= q_n;
      last_id_r <= last_id_n;
      busy_r    <= (state_n != ST_IDLE);
    end
  end

  assign gnt     = gnt_r;
  assign ack     = ack_r;
  assign q       = q_r;
  assign busy    = busy_r;
  assign last_id = last_id_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table of single writes,
// hand-written multi-cycle sequences, and an ack-driven scoreboard.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  gnt;
  logic [N-1:0]  ack;
  logic [DW-1:0] q;
  logic          busy;
  logic [1:0]    last_id;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct { int id; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [N-1:0]  req;
    logic [DW-1:0] data;
    logic [N-1:0]  exp_gnt;
    int            exp_id;
  } vec_t;

  vec_t vecs[5];

  reg_write_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .gnt(gnt), .ack(ack), .q(q), .busy(busy), .last_id(last_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n);
    int seen;
    seen = 0;
    for (int c = 0; c < 40 && seen < n; c++) begin
      tick();
      if (|ack) seen++;
    end
    chk("ack_count", seen, n);
  endtask

  // Scoreboard and invariant monitor, sampled on the falling edge.
  logic [N-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
      if (|ack) begin
        chk("ack_after_gnt", 32'(ack), 32'(prev_gnt));
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_ack", 32'(ack), 32'(1) << e.id);
          chk("sb_q", 32'(q), 32'(e.data));
          chk("sb_last_id", 32'(last_id), 32'(e.id));
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    vecs[0] = '{4'b0100, 8'hA5, 4'b0100, 2};
    vecs[1] = '{4'b0001, 8'h5A, 4'b0001, 0};
    vecs[2] = '{4'b1000, 8'h00, 4'b1000, 3};
    vecs[3] = '{4'b0010, 8'hFF, 4'b0010, 1};
    vecs[4] = '{4'b1000, 8'h81, 4'b1000, 3};

    // Reset held with all requests active
    reset = 1'b1; req = 4'hF; wdata = '0;
    tick();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_last_id", 32'(last_id), 32'd0);
      tick();
    end
    reset = 1'b0; req = '0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single writes from the vector table
    for (int v = 0; v < 5; v++) begin
      wdata = {N{~vecs[v].data}};
      wdata[vecs[v].exp_id*DW +: DW] = vecs[v].data;
      req = vecs[v].req;
      sb.push_back('{vecs[v].exp_id, vecs[v].data});
      tick();
      chk("vec_gnt", 32'(gnt), 32'(vecs[v].exp_gnt));
      chk("vec_busy1", 32'(busy), 32'd1);
      chk("vec_ack_early", 32'(ack), 32'd0);
      tick();
      chk("vec_q", 32'(q), 32'(vecs[v].data));
      chk("vec_ack", 32'(ack), 32'(vecs[v].exp_gnt));
      chk("vec_last_id", 32'(last_id), 32'(vecs[v].exp_id));
      req = '0;
      tick();
      chk("vec_busy0", 32'(busy), 32'd0);
      chk("vec_gnt0", 32'(gnt), 32'd0);
      chk("vec_ack0", 32'(ack), 32'd0);
    end

    // Round-robin with every requester active
    for (int i = 0; i < N; i++) wdata[i*DW +: DW] = 8'h10 + 8'(i);
    sb.push_back('{0, 8'h10}); sb.push_back('{1, 8'h11});
    sb.push_back('{2, 8'h12}); sb.push_back('{3, 8'h13});
    sb.push_back('{0, 8'h10});
    req = 4'hF;
    wait_acks(5);
    req = '0;
    tick(); tick();
    chk("rr_idle", 32'(busy), 32'd0);

    // Request withdrawn during GRANT still completes
    wdata[1*DW +: DW] = 8'h3C;
    req = 4'b0010;
    sb.push_back('{1, 8'h3C});
    tick();
    chk("wd_gnt", 32'(gnt), 32'b0010);
    req = '0;
    tick();
    chk("wd_ack", 32'(ack), 32'b0010);
    chk("wd_q", 32'(q), 32'h3C);
    tick();
    chk("wd_idle", 32'(busy), 32'd0);

    // Reset during GRANT drops the write
    wdata[2*DW +: DW] = 8'hFF;
    req = 4'b0100;
    tick();
    chk("mid_gnt", 32'(gnt), 32'b0100);
    reset = 1'b1;
    tick();
    chk("mid_q", 32'(q), 32'd0);
    chk("mid_ack", 32'(ack), 32'd0);
    chk("mid_gnt0", 32'(gnt), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);

    // Wrap and fairness between requesters 0 and 3; first grant after reset to 0
    wdata[0*DW +: DW] = 8'h70;
    wdata[3*DW +: DW] = 8'h73;
    sb.push_back('{0, 8'h70}); sb.push_back('{3, 8'h73});
    sb.push_back('{0, 8'h70}); sb.push_back('{3, 8'h73});
    reset = 1'b0;
    req = 4'b1001;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'b0001);
    wait_acks(4);
    req = '0;
    tick(); tick();
    chk("wrap_idle", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
